led_panel_video_bcm: RTL
========================

LED_PANEL_VIDEO_BCM -- requirements
Module: led_panel_video_bcm

Interface
REQ-001 Parameter PANEL_COLS, 64, columns shifted per scan row (power of two, >=2).
REQ-002 Parameter SCAN_ROWS, 32, scan rows per panel half (power of two, >=2).
REQ-003 Parameter COLOR_BITS, 8, bits per colour channel (1..8).
REQ-004 Parameter N_FRAMES, 20, frames stored in the video memory (>=1).
REQ-005 Parameter REFRESH_PER_FRAME, 4, complete panel refreshes per video frame (>=1).
REQ-006 Parameter CLK_DIV, 3, clk cycles per LP_CLK half-period (>=2).
REQ-007 Parameter BASE_DELAY, 10, LP ticks of display time for bit plane 0.
REQ-008 clk  input  1  system clock; all logic on its rising edge; reset is synchronous and active-high.
REQ-009 rst  input  1  synchronous active-high reset.
REQ-010 init  input  1  start/continue playback.
REQ-011 mem_addr  output  clog2(N_FRAMES*SCAN_ROWS*PANEL_COLS)  video memory read address.
REQ-012 mem_data  input  6*COLOR_BITS  pixel word {upper R,G,B, lower R,G,B}, 1-cycle read latency.
REQ-013 LP_CLK  output  1  panel shift clock.
REQ-014 LATCH  output  1  active-high latch pulse.
REQ-015 NOE  output  1  active-high output disable.
REQ-016 ROW  output  clog2(SCAN_ROWS)  scan row address.
REQ-017 RGB0, RGB1  output  3 each  upper/lower half colour bits.
REQ-018 frame_idx  output  clog2(N_FRAMES)  frame being displayed; frame_done  output  1  one-clk pulse on frame advance.

Function
REQ-019 The FSM SHALL have states IDLE, SHIFT, BLANK, LATCH, SHOW and NEXT.
REQ-020 IDLE: NOE=1, LP_CLK=0; init=1 moves to SHIFT at row 0, plane 0, column 0.
REQ-021 SHIFT: one slot of 2*CLK_DIV clk per column; mem_addr = frame_idx*SCAN_ROWS*PANEL_COLS + ROW*PANEL_COLS + col in slot cycle 0; RGB0/RGB1 = bit [plane] of each channel, registered in slot cycle 1; LP_CLK high in slot cycles CLK_DIV..2*CLK_DIV-1.
REQ-022 After the column PANEL_COLS-1 slot, BLANK SHALL hold NOE=1 for CLK_DIV clk, then LATCH SHALL assert LATCH for CLK_DIV clk, ROW being updated to the shifted row during BLANK.
REQ-023 SHOW SHALL hold NOE=0 for exactly BASE_DELAY<<plane LP ticks (tick = 2*CLK_DIV clk) using a delay counter wide enough for BASE_DELAY<<(COLOR_BITS-1).
REQ-024 NEXT SHALL advance plane; plane wrap (COLOR_BITS-1 -> 0) advances row; row wrap advances refresh count; refresh-count wrap (REFRESH_PER_FRAME-1 -> 0) advances frame_idx, wrapping N_FRAMES-1 -> 0, and pulses frame_done.
REQ-025 init is sampled only in NEXT at a refresh boundary (last plane of row SCAN_ROWS-1): init=0 enters IDLE; otherwise playback continues.
REQ-026 LP_CLK SHALL be 0 and RGB0/RGB1 SHALL hold their last values outside SHIFT.
REQ-027 NOE SHALL be 0 only in SHOW.

Reset
REQ-028 rst=1 SHALL force, on the next edge and regardless of state: IDLE, LP_CLK=0, LATCH=0, NOE=1, ROW=0, RGB0=RGB1=0, mem_addr=0, frame_idx=0, frame_done=0, all counters 0.
REQ-029 rst asserted mid-SHIFT or mid-SHOW SHALL abandon the row; no partial latch SHALL occur.

Configuration
REQ-030 Macro LED_PANEL_PAUSE_EN SHALL add input pause (1 bit): when 1, the frame advance of REQ-024 is suppressed (refresh count still wraps, frame_idx holds, no frame_done); without the macro no pause port exists and frames always advance.

Structure
REQ-031 Package led_panel_pkg SHALL hold the FSM state enumeration and the RGB-word field offsets.
REQ-032 Sub-module bcm_plane_timer SHALL implement the LP tick divider and the BASE_DELAY<<plane display counter with done flag.

Verification (COLS=4, ROWS=2, BITS=2, N_FRAMES=3, REFRESH=2, CLK_DIV=2, BASE_DELAY=3)
REQ-033 rst=1 in SHOW, then rst=0 with init=0 -> NOE=1, ROW=0, frame_idx=0, LP_CLK stays 0.
REQ-034 init=1, mem_data upper R=2'b10 -> plane 0 shifts RGB0[2]=0, plane 1 shifts RGB0[2]=1; 4 LP_CLK rising edges per plane.
REQ-035 Measure SHOW -> NOE low 12 clk for plane 0, 24 clk for plane 1.
REQ-036 Run 6 refreshes -> frame_done pulses 3 times, frame_idx 0->1->2->0, mem_addr base 0,8,16,0.
REQ-037 Drop init mid-row 1 -> current refresh completes, then IDLE with NOE=1.
REQ-038 With LED_PANEL_PAUSE_EN, pause=1 for 4 refreshes -> frame_idx constant, no frame_done.

Source files
------------

// File: rtl/led_panel_pkg.sv
// Shared definitions for the LED panel BCM driver: FSM state encoding and
// the layout of colour channels inside the 6*COLOR_BITS pixel word.
package led_panel_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_BLANK,
    ST_LATCH,
    ST_SHOW,
    ST_NEXT
  } state_t;

  // Channel slots in mem_data, counted in COLOR_BITS-wide fields from the LSB.
  localparam int F_LB     = 0;
  localparam int F_LG     = 1;
  localparam int F_LR     = 2;
  localparam int F_UB     = 3;
  localparam int F_UG     = 4;
  localparam int F_UR     = 5;
  localparam int N_FIELDS = 6;

endpackage

// File: rtl/bcm_plane_timer.sv
// Display-time counter for one bit plane: divides clk into LP ticks of
// 2*CLK_DIV cycles and flags the last cycle of BASE_DELAY<<plane ticks.
module bcm_plane_timer #(
  parameter int COLOR_BITS = 8,
  parameter int CLK_DIV    = 3,
  parameter int BASE_DELAY = 10
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          en,
  input  logic [((COLOR_BITS > 1) ? $clog2(COLOR_BITS) : 1)-1:0] plane,
  output logic                                          done
);

  localparam int TICK    = 2 * CLK_DIV;
  localparam int DIV_W   = $clog2(TICK);
  localparam int MAX_DLY = BASE_DELAY << (COLOR_BITS - 1);
  localparam int DLY_W   = $clog2(MAX_DLY + 1);

  logic [DIV_W-1:0] div_q;
  logic [DLY_W-1:0] dly_q;
  logic [DLY_W-1:0] target;
  logic             tick_end;

  assign target   = DLY_W'(BASE_DELAY) << plane;
  assign tick_end = (div_q == DIV_W'(TICK - 1));
  assign done     = en && tick_end && (dly_q == target - 1'b1);

  // Counters sit at zero whenever the panel is not showing, so the first
  // enabled cycle is cycle 0 of tick 0.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      div_q <= '0;
      dly_q <= '0;
    end else if (tick_end) begin
      div_q <= '0;
      dly_q <= dly_q + 1'b1;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

endmodule

// File: rtl/led_panel_video_bcm.sv
// HUB75-style LED panel driver with binary-coded-modulation bit planes and
// multi-frame video playback. Optional macro LED_PANEL_PAUSE_EN adds a pause input.
module led_panel_video_bcm
  import led_panel_pkg::*;
#(
  parameter int PANEL_COLS        = 64,
  parameter int SCAN_ROWS         = 32,
  parameter int COLOR_BITS        = 8,
  parameter int N_FRAMES          = 20,
  parameter int REFRESH_PER_FRAME = 4,
  parameter int CLK_DIV           = 3,
  parameter int BASE_DELAY        = 10
) (
  input  logic                                                  clk,
  input  logic                                                  rst,
  input  logic                                                  init,
`ifdef LED_PANEL_PAUSE_EN
  input  logic                                                  pause,
`endif
  output logic [$clog2(N_FRAMES*SCAN_ROWS*PANEL_COLS)-1:0]      mem_addr,
  input  logic [6*COLOR_BITS-1:0]                               mem_data,
  output logic                                                  LP_CLK,
  output logic                                                  LATCH,
  output logic                                                  NOE,
  output logic [$clog2(SCAN_ROWS)-1:0]                          ROW,
  output logic [2:0]                                            RGB0,
  output logic [2:0]                                            RGB1,
  output logic [((N_FRAMES > 1) ? $clog2(N_FRAMES) : 1)-1:0]    frame_idx,
  output logic                                                  frame_done
);

  localparam int AW  = $clog2(N_FRAMES * SCAN_ROWS * PANEL_COLS);
  localparam int RW  = $clog2(SCAN_ROWS);
  localparam int CW  = $clog2(PANEL_COLS);
  localparam int FW  = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1;
  localparam int PW  = (COLOR_BITS > 1) ? $clog2(COLOR_BITS) : 1;
  localparam int RCW = (REFRESH_PER_FRAME > 1) ? $clog2(REFRESH_PER_FRAME) : 1;
  localparam int SCW = $clog2(2 * CLK_DIV);

  state_t           state;
  logic [SCW-1:0]   sc;
  logic [CW-1:0]    col;
  logic [RW-1:0]    row;
  logic [PW-1:0]    plane;
  logic [RCW-1:0]   rcnt;

  logic [SCW-1:0]   sc_nx;
  logic [CW-1:0]    col_nx;
  logic             show_done;
  logic             pause_i;

  logic [COLOR_BITS-1:0] ch [N_FIELDS];

  logic             last_plane, last_row, last_rcnt, refresh_end, frame_adv, stop;
  logic [PW-1:0]    nx_plane;
  logic [RW-1:0]    nx_row;
  logic [RCW-1:0]   nx_rcnt;
  logic [FW-1:0]    nx_frame;

`ifdef LED_PANEL_PAUSE_EN
  assign pause_i = pause;
`else
  assign pause_i = 1'b0;
`endif

  function automatic logic [AW-1:0] pix_addr(input logic [FW-1:0] f,
                                             input logic [RW-1:0] r,
                                             input logic [CW-1:0] c);
    return AW'(f) * AW'(SCAN_ROWS * PANEL_COLS) + AW'({r, c});
  endfunction

  assign sc_nx  = sc + 1'b1;
  assign col_nx = col + 1'b1;

  always_comb begin
    for (int f = 0; f < N_FIELDS; f++) begin
      ch[f] = mem_data[f*COLOR_BITS +: COLOR_BITS];
    end
  end

  // Plane/row/refresh/frame carry chain evaluated for the NEXT state.
  always_comb begin
    last_plane  = (plane == PW'(COLOR_BITS - 1));
    last_row    = (row == RW'(SCAN_ROWS - 1));
    last_rcnt   = (rcnt == RCW'(REFRESH_PER_FRAME - 1));
    refresh_end = last_plane && last_row;
    frame_adv   = refresh_end && last_rcnt && !pause_i;
    stop        = refresh_end && !init;
    nx_plane    = last_plane ? '0 : plane + 1'b1;
    nx_row      = row;
    if (last_plane) nx_row = last_row ? '0 : row + 1'b1;
    nx_rcnt     = rcnt;
    if (refresh_end) nx_rcnt = last_rcnt ? '0 : rcnt + 1'b1;
    nx_frame    = frame_idx;
    if (frame_adv) nx_frame = (frame_idx == FW'(N_FRAMES - 1)) ? '0 : frame_idx + 1'b1;
  end

  bcm_plane_timer #(
    .COLOR_BITS (COLOR_BITS),
    .CLK_DIV    (CLK_DIV),
    .BASE_DELAY (BASE_DELAY)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .en    (state == ST_SHOW),
    .plane (plane),
    .done  (show_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      sc         <= '0;
      col        <= '0;
      row        <= '0;
      plane      <= '0;
      rcnt       <= '0;
      frame_idx  <= '0;
      mem_addr   <= '0;
      LP_CLK     <= 1'b0;
      LATCH      <= 1'b0;
      NOE        <= 1'b1;
      ROW        <= '0;
      RGB0       <= '0;
      RGB1       <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          NOE    <= 1'b1;
          LP_CLK <= 1'b0;
          if (init) begin
            state    <= ST_SHIFT;
            sc       <= '0;
            col      <= '0;
            row      <= '0;
            plane    <= '0;
            mem_addr <= pix_addr(frame_idx, '0, '0);
          end
        end
        // Slot cycle 0 presents the address, cycle 1 sees the read data.
        ST_SHIFT: begin
          if (sc == SCW'(2 * CLK_DIV - 1)) begin
            sc     <= '0;
            LP_CLK <= 1'b0;
            if (col == CW'(PANEL_COLS - 1)) begin
              state <= ST_BLANK;
              col   <= '0;
              ROW   <= row;
            end else begin
              col      <= col_nx;
              mem_addr <= pix_addr(frame_idx, row, col_nx);
            end
          end else begin
            sc     <= sc_nx;
            LP_CLK <= (sc_nx >= SCW'(CLK_DIV));
            if (sc == SCW'(1)) begin
              RGB0 <= {ch[F_UR][plane], ch[F_UG][plane], ch[F_UB][plane]};
              RGB1 <= {ch[F_LR][plane], ch[F_LG][plane], ch[F_LB][plane]};
            end
          end
        end
        ST_BLANK: begin
          if (sc == SCW'(CLK_DIV - 1)) begin
            sc    <= '0;
            state <= ST_LATCH;
            LATCH <= 1'b1;
          end else begin
            sc <= sc_nx;
          end
        end
        ST_LATCH: begin
          if (sc == SCW'(CLK_DIV - 1)) begin
            sc    <= '0;
            state <= ST_SHOW;
            LATCH <= 1'b0;
            NOE   <= 1'b0;
          end else begin
            sc <= sc_nx;
          end
        end
        ST_SHOW: begin
          if (show_done) begin
            state <= ST_NEXT;
            NOE   <= 1'b1;
          end
        end
        ST_NEXT: begin
          plane      <= nx_plane;
          row        <= nx_row;
          rcnt       <= nx_rcnt;
          frame_idx  <= nx_frame;
          frame_done <= frame_adv;
          if (stop) begin
            state <= ST_IDLE;
          end else begin
            state    <= ST_SHIFT;
            sc       <= '0;
            col      <= '0;
            mem_addr <= pix_addr(nx_frame, nx_row, '0);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
